cdr_loop_filter: RTL and testbench
==================================

// Module: cdr_loop_filter
// PURPOSE
//  Digital loop filter and step sequencer for the phase rotator. Integrates per-cycle
//  early/late votes from the bang-bang phase detector and issues one-cycle inc/dec step
//  pulses to the rotator, never both at once. After each step it ignores votes for a
//  hold-off period so the rotator mux can settle. Reports lock from step activity.
// PARAMETERS
//  ACC_W     5   signed accumulator width; must satisfy 2^(ACC_W-1) > THRESH
//  THRESH    8   net vote count that triggers a step (>=1)
//  HOLDOFF   4   cycles of discarded votes after each step (>=1)
//  LOCK_WIN  64  lock evaluation window length in cycles (>=2)
//  LOCK_MAX  2   max steps per window for locked=1
// PORTS
//  clk     in   1  single clock; all state updates on rising edge
//  rst     in   1  synchronous reset, active-high
//  up      in   1  vote: sampled phase early, advance (+1)
//  dn      in   1  vote: sampled phase late, retard (-1)
//  freeze  in   1  1 = discard votes, hold accumulator; hold-off and lock timing keep running
//  inc     out  1  one-cycle pulse: rotator count +1
//  dec     out  1  one-cycle pulse: rotator count -1
//  locked  out  1  lock status, updated once per window
// BEHAVIOUR
//  Reset (rst=1 at edge): inc=0, dec=0, locked=0, acc=0, state=TRACK, hold_cnt=0,
//   win_cnt=0, step_cnt=0. Reset mid-HOLD or mid-pulse takes effect at that edge.
//  Vote decode: up&~dn=+1; dn&~up=-1; up==dn gives 0 (no vote). Freeze forces 0.
//  FSM states: TRACK, HOLD.
//   TRACK: acc_n = acc + vote.
//    If acc_n==+THRESH: inc<=1, acc<=0, go to HOLD, hold_cnt<=HOLDOFF.
//    If acc_n==-THRESH: dec<=1, acc<=0, go to HOLD, hold_cnt<=HOLDOFF.
//    Otherwise acc<=acc_n.
//   HOLD: inc<=0, dec<=0, votes discarded, acc stays 0, hold_cnt<=hold_cnt-1.
//    When hold_cnt==1 at an edge, go to TRACK.
//  Latency: threshold vote sampled at edge N gives a pulse high from edge N to N+1.
//   Votes at edges N+1..N+HOLDOFF are discarded. The first counted vote is at edge
//   N+HOLDOFF+1. Minimum step spacing is THRESH+HOLDOFF cycles.
//  acc is always in (-THRESH, +THRESH), so no overflow or wrap is possible. inc and dec
//   are mutually exclusive by construction.
//  Lock: win_cnt counts 0..LOCK_WIN-1 and wraps. step_cnt increments on each inc/dec
//   pulse and saturates at LOCK_MAX+1. On the edge where win_cnt==LOCK_WIN-1:
//   locked <= (step_cnt incl. any pulse this cycle) <= LOCK_MAX, and step_cnt is cleared.
//   locked is otherwise unchanged.
// TESTING
//  1. rst=1 for 3 cycles with up=1 -> inc=dec=locked=0. Release, 8 up votes -> inc=1
//     for exactly the cycle after the 8th vote edge.
//  2. up=1 held for 40 cycles -> inc pulses on cycles 8, 20, 32 (12-cycle spacing);
//     dec stays 0.
//  3. 7 up, 1 dn, 2 up -> acc 7,6,7,8 -> single inc after 10th vote. up=dn=1 or
//     up=dn=0 cycles leave acc unchanged.
//  4. up/dn alternating every cycle for 128 cycles -> no pulses; locked=1 after
//     first window end (edge 64).
//  5. 7 up, then freeze=1 with up=1 for 10 cycles -> no pulse. freeze=0, 1 up ->
//     inc next cycle.
//  6. 8 dn -> dec pulse. Assert rst during HOLD -> outputs 0 next cycle, state TRACK;
//     8 up after release -> inc with normal latency.

Source files
------------

// File: rtl/cdr_loop_filter.sv
// cdr_loop_filter
//   Bang-bang CDR loop filter and phase-rotator step sequencer.
//   Early/late votes are integrated in a signed accumulator. When the
//   accumulator reaches +/-THRESH, a one-cycle inc/dec step pulse is issued.
//   After each step, votes are discarded for HOLDOFF cycles while the rotator
//   mux settles. Lock is reported once per LOCK_WIN-cycle window, based on how
//   many steps occurred in that window.
//
//   Interface timing: up/dn/freeze are plain level inputs sampled on every
//   rising clock edge. There is no handshake. inc/dec are registered pulses,
//   high for exactly one cycle. state_dbg exposes the FSM state
//   (0 = TRACK, 1 = HOLD) so checkers can observe it.
//
//   Parameter constraints: 2^(ACC_W-1) > THRESH >= 1, HOLDOFF >= 1,
//   LOCK_WIN >= 2, LOCK_MAX >= 0.

module cdr_loop_filter #(
  parameter int ACC_W    = 5,
  parameter int THRESH   = 8,
  parameter int HOLDOFF  = 4,
  parameter int LOCK_WIN = 64,
  parameter int LOCK_MAX = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic up,
  input  logic dn,
  input  logic freeze,
  output logic inc,
  output logic dec,
  output logic locked,
  output logic state_dbg
);

  typedef enum logic {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam int WIN_W  = (LOCK_WIN < 2) ? 1 : $clog2(LOCK_WIN);
  localparam int STEP_W = $clog2(LOCK_MAX + 2);

  localparam logic signed [ACC_W-1:0] THRESH_P  = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] THRESH_N  = ACC_W'(-THRESH);
  localparam logic signed [ACC_W-1:0] VOTE_UP   = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] VOTE_DN   = ACC_W'(-1);
  localparam logic [HOLD_W-1:0]       HOLD_LOAD = HOLD_W'(HOLDOFF);
  localparam logic [HOLD_W-1:0]       HOLD_ONE  = HOLD_W'(1);
  localparam logic [WIN_W-1:0]        WIN_LAST  = WIN_W'(LOCK_WIN - 1);
  localparam logic [WIN_W-1:0]        WIN_ONE   = WIN_W'(1);
  localparam logic [STEP_W-1:0]       STEP_SAT  = STEP_W'(LOCK_MAX + 1);
  localparam logic [STEP_W-1:0]       STEP_OK   = STEP_W'(LOCK_MAX);
  localparam logic [STEP_W-1:0]       STEP_ONE  = STEP_W'(1);

  // Registered state
  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic [HOLD_W-1:0]         hold_cnt;
  logic [WIN_W-1:0]          win_cnt;
  logic [STEP_W-1:0]         step_cnt;

  // Next-state values
  state_t                    state_n;
  logic signed [ACC_W-1:0]   acc_n;
  logic [HOLD_W-1:0]         hold_n;
  logic                      inc_n;
  logic                      dec_n;
  logic [WIN_W-1:0]          win_n;
  logic [STEP_W-1:0]         step_n;
  logic                      locked_n;

  // Intermediate values
  logic signed [ACC_W-1:0]   vote;
  logic signed [ACC_W-1:0]   acc_sum;
  logic                      win_end;
  logic                      pulse_now;
  logic [STEP_W-1:0]         step_incl;

  assign state_dbg = state;

  // Vote decode: conflicting or absent votes, and any frozen cycle, count as zero.
  always_comb begin
    vote = '0;
    if (!freeze) begin
      if (up && !dn) begin
        vote = VOTE_UP;
      end else if (dn && !up) begin
        vote = VOTE_DN;
      end
    end
  end

  // TRACK/HOLD next-state logic, including accumulator update and step pulse generation.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    hold_n  = hold_cnt;
    inc_n   = 1'b0;
    dec_n   = 1'b0;
    acc_sum = acc + vote;
    case (state)
      TRACK: begin
        if (acc_sum == THRESH_P) begin
          inc_n   = 1'b1;
          acc_n   = '0;
          hold_n  = HOLD_LOAD;
          state_n = HOLD;
        end else if (acc_sum == THRESH_N) begin
          dec_n   = 1'b1;
          acc_n   = '0;
          hold_n  = HOLD_LOAD;
          state_n = HOLD;
        end else begin
          acc_n = acc_sum;
        end
      end
      HOLD: begin
        // Votes are discarded while the rotator settles; the accumulator stays cleared.
        acc_n  = '0;
        hold_n = hold_cnt - HOLD_ONE;
        if (hold_cnt == HOLD_ONE) begin
          state_n = TRACK;
        end
      end
      default: begin
        state_n = TRACK;
        acc_n   = '0;
        hold_n  = '0;
      end
    endcase
  end

  // Lock window: count step pulses (including one live in the closing cycle) and judge at window end.
  always_comb begin
    pulse_now = inc | dec;
    win_end   = (win_cnt == WIN_LAST);
    step_incl = step_cnt;
    if (pulse_now && (step_cnt != STEP_SAT)) begin
      step_incl = step_cnt + STEP_ONE;
    end
    win_n    = win_cnt + WIN_ONE;
    step_n   = step_incl;
    locked_n = locked;
    if (win_end) begin
      win_n    = '0;
      step_n   = '0;
      locked_n = (step_incl <= STEP_OK);
    end
  end

  // State register with synchronous reset; reset overrides any hold-off or pulse in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TRACK;
      acc      <= '0;
      hold_cnt <= '0;
      inc      <= 1'b0;
      dec      <= 1'b0;
      win_cnt  <= '0;
      step_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      hold_cnt <= hold_n;
      inc      <= inc_n;
      dec      <= dec_n;
      win_cnt  <= win_n;
      step_cnt <= step_n;
      locked   <= locked_n;
    end
  end

endmodule

// File: tb/tb_cdr_loop_filter.sv
// tb_cdr_loop_filter
//   Directed vector table, hand-written multi-cycle sequences, and randomized
//   stimulus. Every cycle is compared against a behavioural model that counts
//   votes, discarded cycles, and steps per window.

module tb_cdr_loop_filter;

  localparam int ACC_W    = 5;
  localparam int THRESH   = 8;
  localparam int HOLDOFF  = 4;
  localparam int LOCK_WIN = 64;
  localparam int LOCK_MAX = 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up = 1'b0;
  logic dn = 1'b0;
  logic freeze = 1'b0;
  logic inc, dec, locked, state_dbg;

  always #5 clk = ~clk;

  cdr_loop_filter #(
    .ACC_W(ACC_W), .THRESH(THRESH), .HOLDOFF(HOLDOFF),
    .LOCK_WIN(LOCK_WIN), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .dn(dn), .freeze(freeze),
    .inc(inc), .dec(dec), .locked(locked), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];   // {inc, dec, locked, hold}

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // acc: net vote count; disc: how many upcoming edges still discard votes;
  // edge_idx: position within the lock window; steps: pulses seen in the window.
  int m_acc = 0, m_disc = 0, m_edge = 0, m_steps = 0;
  bit m_inc = 0, m_dec = 0, m_locked = 0;

  task automatic model_edge(input logic u, input logic d, input logic f, input logic r);
    int v;
    if (r) begin
      m_acc = 0; m_disc = 0; m_edge = 0; m_steps = 0;
      m_inc = 0; m_dec = 0; m_locked = 0;
    end else begin
      // Lock bookkeeping sees the pulse currently on the outputs.
      if (m_inc || m_dec) m_steps++;
      if (m_edge == LOCK_WIN - 1) begin
        m_locked = (m_steps <= LOCK_MAX);
        m_steps  = 0;
        m_edge   = 0;
      end else begin
        m_edge++;
      end
      m_inc = 0;
      m_dec = 0;
      v = 0;
      if (!f && u && !d) v = 1;
      if (!f && d && !u) v = -1;
      if (m_disc > 0) begin
        m_disc--;
      end else begin
        m_acc += v;
        if (m_acc == THRESH) begin
          m_inc = 1; m_acc = 0; m_disc = HOLDOFF;
        end else if (m_acc == -THRESH) begin
          m_dec = 1; m_acc = 0; m_disc = HOLDOFF;
        end
      end
    end
    exp_q.push_back({m_inc, m_dec, m_locked, (m_disc > 0)});
  endtask

  // ---------------- driver ----------------
  logic obs_inc, obs_dec, obs_locked, obs_state;

  task automatic cyc(input logic u, input logic d, input logic f, input logic r);
    logic [3:0] e;
    up = u; dn = d; freeze = f; rst = r;
    @(posedge clk);
    model_edge(u, d, f, r);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("inc", inc, e[3]);
      chk("dec", dec, e[2]);
      chk("locked", locked, e[1]);
      chk("state", state_dbg, e[0]);
    end
    obs_inc = inc; obs_dec = dec; obs_locked = locked; obs_state = state_dbg;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic  up, dn, frz, rst;
    logic  e_inc, e_dec, e_lock;
    string tag;
  } vec_t;

  vec_t vecs[$];

  task automatic add_n(input int n, input logic u, input logic d, input logic f, input logic r,
                       input logic ei, input logic ed, input logic el, input string tag);
    vec_t v;
    v.up = u; v.dn = d; v.frz = f; v.rst = r;
    v.e_inc = ei; v.e_dec = ed; v.e_lock = el; v.tag = tag;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int pulses[$];
    int n_inc, n_dec;
    logic l63, l64;
    int p, q;
    logic ru, rd, rf, rr;

    // Reset with up held, then 8 up votes -> inc in the cycle after the 8th edge.
    add_n(3, 1, 0, 0, 1, 0, 0, 0, "t1_rst");
    add_n(7, 1, 0, 0, 0, 0, 0, 0, "t1_up");
    add_n(1, 1, 0, 0, 0, 1, 0, 0, "t1_inc");
    add_n(1, 0, 0, 0, 0, 0, 0, 0, "t1_after");
    add_n(3, 1, 0, 0, 0, 0, 0, 0, "t1_hold_discard");
    // 7 up, 1 dn, both, none, 2 up -> acc 7,6,6,6,7,8.
    add_n(7, 1, 0, 0, 0, 0, 0, 0, "t3_up7");
    add_n(1, 0, 1, 0, 0, 0, 0, 0, "t3_dn");
    add_n(1, 1, 1, 0, 0, 0, 0, 0, "t3_both");
    add_n(1, 0, 0, 0, 0, 0, 0, 0, "t3_none");
    add_n(1, 1, 0, 0, 0, 0, 0, 0, "t3_up9");
    add_n(1, 1, 0, 0, 0, 1, 0, 0, "t3_inc");
    add_n(4, 0, 0, 0, 0, 0, 0, 0, "t3_hold");
    // 7 up, then frozen up votes do nothing; one more up steps.
    add_n(7, 1, 0, 0, 0, 0, 0, 0, "t5_up7");
    add_n(10, 1, 0, 1, 0, 0, 0, 0, "t5_frz");
    add_n(1, 1, 0, 0, 0, 1, 0, 0, "t5_inc");
    add_n(1, 0, 0, 0, 0, 0, 0, 0, "t5_after");

    foreach (vecs[i]) begin
      cyc(vecs[i].up, vecs[i].dn, vecs[i].frz, vecs[i].rst);
      chk({vecs[i].tag, "_inc"}, obs_inc, vecs[i].e_inc);
      chk({vecs[i].tag, "_dec"}, obs_dec, vecs[i].e_dec);
      chk({vecs[i].tag, "_locked"}, obs_locked, vecs[i].e_lock);
    end

    // Continuous up votes: steps on edges 8, 20, 32.
    cyc(0, 0, 0, 1);
    pulses.delete(); n_dec = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(1, 0, 0, 0);
      if (obs_inc) pulses.push_back(k);
      if (obs_dec) n_dec++;
    end
    chk_int("t2_pulse_count", pulses.size(), 3);
    if (pulses.size() == 3) begin
      chk_int("t2_pulse0", pulses[0], 8);
      chk_int("t2_pulse1", pulses[1], 20);
      chk_int("t2_pulse2", pulses[2], 32);
    end
    chk_int("t2_dec_count", n_dec, 0);

    // Alternating votes: no steps, locked after the first window end.
    cyc(0, 0, 0, 1);
    n_inc = 0; n_dec = 0; l63 = 1'b1; l64 = 1'b0;
    for (int k = 1; k <= 128; k++) begin
      cyc(k[0], ~k[0], 0, 0);
      if (obs_inc) n_inc++;
      if (obs_dec) n_dec++;
      if (k == 63) l63 = obs_locked;
      if (k == 64) l64 = obs_locked;
    end
    chk_int("t4_inc_count", n_inc, 0);
    chk_int("t4_dec_count", n_dec, 0);
    chk("t4_locked_edge63", l63, 1'b0);
    chk("t4_locked_edge64", l64, 1'b1);

    // Continuous up for a full window: 5 steps, so lock is lost at the window end.
    for (int k = 1; k <= 64; k++) begin
      cyc(1, 0, 0, 0);
      if (k == 63) l63 = obs_locked;
      if (k == 64) l64 = obs_locked;
    end
    chk("t4b_locked_edge63", l63, 1'b1);
    chk("t4b_locked_edge64", l64, 1'b0);

    // Exactly LOCK_MAX steps -> locked; a third step live in the closing cycle counts -> unlocked.
    cyc(0, 0, 0, 1);
    for (int w = 0; w < 2; w++) begin
      for (int k = 1; k <= 64; k++) begin
        cyc((k <= 20) || (w == 1 && k >= 56 && k <= 63), 0, 0, 0);
        if (w == 1 && k == 63) chk("lock_edge_pulse_set", obs_inc, 1'b1);
        if (k == 64) l64 = obs_locked;
      end
      chk(w == 0 ? "lock_two_steps" : "lock_three_steps", l64, (w == 0));
    end

    // 8 dn -> dec; reset during hold; then 8 up with normal latency.
    cyc(0, 0, 0, 1);
    for (int k = 1; k <= 8; k++) cyc(0, 1, 0, 0);
    chk("t6_dec", obs_dec, 1'b1);
    chk("t6_dec_no_inc", obs_inc, 1'b0);
    cyc(0, 1, 0, 0);
    chk("t6_in_hold", obs_state, 1'b1);
    cyc(1, 0, 0, 1);
    chk("t6_rst_inc", obs_inc, 1'b0);
    chk("t6_rst_dec", obs_dec, 1'b0);
    chk("t6_rst_state", obs_state, 1'b0);
    n_inc = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 0, 0, 0);
      if (obs_inc) n_inc++;
    end
    chk("t6_inc_after_rst", obs_inc, 1'b1);
    chk_int("t6_inc_count", n_inc, 1);
    // Reset while the pulse is high clears it at that edge.
    cyc(0, 0, 0, 1);
    chk("t6_rst_mid_pulse", obs_inc, 1'b0);

    // Randomized stimulus with segment-wise vote bias.
    cyc(0, 0, 0, 1);
    for (int s = 0; s < 40; s++) begin
      p = $urandom_range(10, 90);
      q = $urandom_range(10, 90);
      for (int k = 0; k < 100; k++) begin
        ru = ($urandom_range(0, 99) < p);
        rd = ($urandom_range(0, 99) < q);
        rf = ($urandom_range(0, 15) == 0);
        rr = ($urandom_range(0, 499) == 0);
        cyc(ru, rd, rf, rr);
      end
    end

    chk_int("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
